// File: rtl/core_pkg.sv
// Shared encodings between controlUnit and processor_datapath: bus sources,
// ALU operations and the bit positions of the write/increment enable vectors.
package core_pkg;

  typedef enum logic [3:0] {
    BUS_ZERO = 4'd0,
    BUS_PC   = 4'd1,
    BUS_DMEM = 4'd2,
    BUS_R    = 4'd3,
    BUS_IR   = 4'd4,
    BUS_RL   = 4'd5,
    BUS_RC   = 4'd6,
    BUS_RP   = 4'd7,
    BUS_RQ   = 4'd8,
    BUS_R1   = 4'd9,
    BUS_AC   = 4'd10,
    BUS_IMEM = 4'd11
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_INC  = 3'd4,
    ALU_CLR  = 3'd5
  } alu_op_e;

  localparam int WR_AC = 0;
  localparam int WR_R1 = 1;
  localparam int WR_RQ = 2;
  localparam int WR_RP = 3;
  localparam int WR_RC = 4;
  localparam int WR_RL = 5;
  localparam int WR_IR = 6;
  localparam int WR_PC = 7;
  localparam int WR_R  = 8;
  localparam int WR_AR = 9;

  localparam int INC_RQ = 0;
  localparam int INC_RP = 1;
  localparam int INC_RC = 2;
  localparam int INC_PC = 3;

endpackage

// File: rtl/processor_datapath_alu.sv
// Combinational ALU: result is always truncated to REG_WIDTH bits.
module alu
  import core_pkg::*;
#(
  parameter int REG_WIDTH = 12
) (
  input  logic [2:0]           i_alu_op,
  input  logic [REG_WIDTH-1:0] i_ac,
  input  logic [REG_WIDTH-1:0] i_bus,
  output logic [REG_WIDTH-1:0] o_alu_out
);

  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

  logic [2*REG_WIDTH-1:0] w_prod;

  assign w_prod = {{REG_WIDTH{1'b0}}, i_ac} * {{REG_WIDTH{1'b0}}, i_bus};

  always_comb begin
    o_alu_out = i_bus;
    case (i_alu_op)
      ALU_ADD: o_alu_out = i_ac + i_bus;
      ALU_SUB: o_alu_out = i_ac - i_bus;
      ALU_MUL: o_alu_out = w_prod[REG_WIDTH-1:0];
      ALU_INC: o_alu_out = i_ac + ONE;
      ALU_CLR: o_alu_out = '0;
      default: o_alu_out = i_bus;
    endcase
  end

endmodule

// File: rtl/processor_datapath.sv
// Register/ALU datapath of the core: ten architectural registers, shared bus,
// ALU and Z flag, driven by control words from controlUnit.
module processor_datapath
  import core_pkg::*;
#(
  parameter int REG_WIDTH = 12,
  parameter int INS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [2:0]           aluOp,
  input  logic [3:0]           incReg,
  input  logic [9:0]           wrEnReg,
  input  logic [3:0]           busSel,
  input  logic                 ZWrEn,
  input  logic [REG_WIDTH-1:0] iMemData,
  input  logic [REG_WIDTH-1:0] dMemData,
  output logic [REG_WIDTH-1:0] iAddr,
  output logic [REG_WIDTH-1:0] dAddr,
  output logic [REG_WIDTH-1:0] dMemOut,
  output logic [INS_WIDTH-1:0] ins,
  output logic                 Zout
);

  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

  logic [REG_WIDTH-1:0] r_ar, r_r, r_pc, r_ir, r_rl, r_rc, r_rp, r_rq, r_r1, r_ac;
  logic                 r_z;
  logic [REG_WIDTH-1:0] w_bus;
  logic [REG_WIDTH-1:0] w_alu_out;

  always_comb begin
    w_bus = '0;
    case (busSel)
      BUS_PC:   w_bus = r_pc;
      BUS_DMEM: w_bus = dMemData;
      BUS_R:    w_bus = r_r;
      BUS_IR:   w_bus = r_ir;
      BUS_RL:   w_bus = r_rl;
      BUS_RC:   w_bus = r_rc;
      BUS_RP:   w_bus = r_rp;
      BUS_RQ:   w_bus = r_rq;
      BUS_R1:   w_bus = r_r1;
      BUS_AC:   w_bus = r_ac;
      BUS_IMEM: w_bus = iMemData;
      default:  w_bus = '0;
    endcase
  end

  alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .i_alu_op (aluOp),
    .i_ac     (r_ac),
    .i_bus    (w_bus),
    .o_alu_out(w_alu_out)
  );

  // Plain bus-loaded registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ar <= '0;
      r_r  <= '0;
      r_ir <= '0;
      r_rl <= '0;
      r_r1 <= '0;
      r_ac <= '0;
      r_z  <= 1'b0;
    end else begin
      if (wrEnReg[WR_AR]) r_ar <= w_bus;
      if (wrEnReg[WR_R])  r_r  <= w_bus;
      if (wrEnReg[WR_IR]) r_ir <= w_bus;
      if (wrEnReg[WR_RL]) r_rl <= w_bus;
      if (wrEnReg[WR_R1]) r_r1 <= w_bus;
      if (wrEnReg[WR_AC]) r_ac <= w_alu_out;
      if (ZWrEn)          r_z  <= (w_alu_out == '0);
    end
  end

  // Counting registers: a write in the same cycle takes priority over +1.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_pc <= '0;
      r_rc <= '0;
      r_rp <= '0;
      r_rq <= '0;
    end else begin
      if (wrEnReg[WR_PC])     r_pc <= w_bus;
      else if (incReg[INC_PC]) r_pc <= r_pc + ONE;
      if (wrEnReg[WR_RC])     r_rc <= w_bus;
      else if (incReg[INC_RC]) r_rc <= r_rc + ONE;
      if (wrEnReg[WR_RP])     r_rp <= w_bus;
      else if (incReg[INC_RP]) r_rp <= r_rp + ONE;
      if (wrEnReg[WR_RQ])     r_rq <= w_bus;
      else if (incReg[INC_RQ]) r_rq <= r_rq + ONE;
    end
  end

  assign iAddr   = r_pc;
  assign dAddr   = r_ar;
  assign dMemOut = r_r;
  assign ins     = r_ir[INS_WIDTH-1:0];
  assign Zout    = r_z;

endmodule

// File: tb/tb_processor_datapath.sv
// Directed bench for processor_datapath; internal registers are observed by
// routing them onto R (dMemOut) through the bus.
module tb_processor_datapath;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  aluOp;
  logic [3:0]  incReg;
  logic [9:0]  wrEnReg;
  logic [3:0]  busSel;
  logic        ZWrEn;
  logic [11:0] iMemData, dMemData;
  logic [11:0] iAddr, dAddr, dMemOut;
  logic [7:0]  ins;
  logic        Zout;

  int checks = 0;
  int errors = 0;

  processor_datapath #(.REG_WIDTH(12), .INS_WIDTH(8)) dut (
    .clk(clk), .rstN(rstN), .aluOp(aluOp), .incReg(incReg), .wrEnReg(wrEnReg),
    .busSel(busSel), .ZWrEn(ZWrEn), .iMemData(iMemData), .dMemData(dMemData),
    .iAddr(iAddr), .dAddr(dAddr), .dMemOut(dMemOut), .ins(ins), .Zout(Zout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One control word applied for one rising edge; outputs sampled 1ns after it.
  task automatic step(input logic [3:0] bs, input logic [2:0] op,
                      input logic [9:0] we, input logic [3:0] inc, input logic z);
    @(negedge clk);
    busSel = bs; aluOp = op; wrEnReg = we; incReg = inc; ZWrEn = z;
    @(posedge clk);
    #1;
    busSel = 4'd0; aluOp = 3'd0; wrEnReg = '0; incReg = '0; ZWrEn = 1'b0;
  endtask

  // bit positions: wrEnReg {AR,R,PC,IR,RL,RC,RP,RQ,R1,AC}, incReg {PC,RC,RP,RQ}
  localparam logic [9:0] W_AC = 10'h001, W_R1 = 10'h002, W_RQ = 10'h004, W_RP = 10'h008,
                         W_RC = 10'h010, W_IR = 10'h040, W_PC = 10'h080,
                         W_R  = 10'h100, W_AR = 10'h200;
  localparam logic [3:0] I_PC = 4'h8, I_RC = 4'h4;

  initial begin
    rstN = 1'b0; aluOp = '0; incReg = '0; wrEnReg = '0; busSel = '0; ZWrEn = 1'b0;
    iMemData = '0; dMemData = '0;
    #3;
    chk("rst_iAddr", iAddr, 12'h000);
    chk("rst_dAddr", dAddr, 12'h000);
    chk("rst_dMemOut", dMemOut, 12'h000);
    chk("rst_ins", {4'h0, ins}, 12'h000);
    chk("rst_Z", {11'h0, Zout}, 12'h000);
    @(negedge clk); rstN = 1'b1;
    step(4'd0, 3'd0, '0, '0, 1'b0);
    chk("idle_iAddr", iAddr, 12'h000);

    // PC increment and wrap
    repeat (3) step(4'd0, 3'd0, '0, I_PC, 1'b0);
    chk("pc_inc3", iAddr, 12'h003);
    iMemData = 12'hFFF;
    step(4'd11, 3'd0, W_PC, '0, 1'b0);
    chk("pc_wr_fff", iAddr, 12'hFFF);
    step(4'd0, 3'd0, '0, I_PC, 1'b0);
    chk("pc_wrap", iAddr, 12'h000);

    // Fetch, then PC<-PC with simultaneous inc: write wins, value held
    iMemData = 12'h00B;
    step(4'd11, 3'd0, W_IR, '0, 1'b0);
    chk("fetch_ins", {4'h0, ins}, 12'h00B);
    step(4'd1, 3'd0, W_PC, I_PC, 1'b0);
    chk("pc_wr_wins", iAddr, 12'h000);

    // LDIAC 5, RP<-AC, ADD -> 0xA
    iMemData = 12'h005;
    step(4'd11, 3'd0, W_AC, '0, 1'b0);
    step(4'd10, 3'd0, W_RP, '0, 1'b0);
    step(4'd7, 3'd1, W_AC, '0, 1'b0);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("add_ac", dMemOut, 12'h00A);
    // RP<-AC, SUB -> 0 and Z=1
    step(4'd10, 3'd0, W_RP, '0, 1'b0);
    step(4'd7, 3'd2, W_AC, '0, 1'b1);
    chk("sub_z1", {11'h0, Zout}, 12'h001);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("sub_ac0", dMemOut, 12'h000);

    // MUL wrap: 0x40*0x41 = 0x1040 -> 0x040, Z=0
    iMemData = 12'h040;
    step(4'd11, 3'd0, W_AC, '0, 1'b0);
    iMemData = 12'h041;
    step(4'd11, 3'd0, W_RQ, '0, 1'b0);
    step(4'd8, 3'd3, W_AC, '0, 1'b1);
    chk("mul_z0", {11'h0, Zout}, 12'h000);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("mul_ac", dMemOut, 12'h040);

    // AC INC wrap from 0xFFF
    iMemData = 12'hFFF;
    step(4'd11, 3'd0, W_AC, '0, 1'b0);
    step(4'd0, 3'd4, W_AC, '0, 1'b1);
    chk("inc_wrap_z", {11'h0, Zout}, 12'h001);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("inc_wrap_ac", dMemOut, 12'h000);

    // RC increments, R1 through bus
    step(4'd0, 3'd0, '0, I_RC, 1'b0);
    step(4'd0, 3'd0, '0, I_RC, 1'b0);
    step(4'd6, 3'd0, W_R, '0, 1'b0);
    chk("rc_inc2", dMemOut, 12'h002);
    iMemData = 12'h3C5;
    step(4'd11, 3'd0, W_R1, '0, 1'b0);
    step(4'd9, 3'd0, W_R, '0, 1'b0);
    chk("r1_path", dMemOut, 12'h3C5);

    // Store path and data memory load
    iMemData = 12'h123;
    step(4'd11, 3'd0, W_AR, '0, 1'b0);
    iMemData = 12'h7AB;
    step(4'd11, 3'd0, W_AC, '0, 1'b0);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("st_dAddr", dAddr, 12'h123);
    chk("st_dMemOut", dMemOut, 12'h7AB);
    dMemData = 12'h055;
    step(4'd2, 3'd0, W_AC, '0, 1'b0);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("ld_dmem", dMemOut, 12'h055);

    // Z loaded without AC write: AC stays 0x7AB, Z=1
    step(4'd11, 3'd0, W_AC, '0, 1'b0);
    step(4'd0, 3'd5, '0, '0, 1'b1);
    chk("z_indep", {11'h0, Zout}, 12'h001);
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("ac_hold", dMemOut, 12'h7AB);

    // Mid-phase async reset, no clock edge involved
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("arst_iAddr", iAddr, 12'h000);
    chk("arst_dAddr", dAddr, 12'h000);
    chk("arst_dMemOut", dMemOut, 12'h000);
    chk("arst_ins", {4'h0, ins}, 12'h000);
    chk("arst_Z", {11'h0, Zout}, 12'h000);
    @(negedge clk); rstN = 1'b1;
    step(4'd10, 3'd0, W_R, '0, 1'b0);
    chk("arst_ac", dMemOut, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor_datapath.md
# processor_datapath

Register/ALU datapath that executes the control words issued by `controlUnit` and returns the current instruction and zero flag to it. Holds the ten architectural registers, the shared bus multiplexer, the ALU and the Z flag. Drives instruction/data memory addresses and write data. One instance per core; `controlUnit` and `processor_datapath` together form a core.

## Interface
- `REG_WIDTH`, 12: width of every register, bus, ALU and memory data word
- `INS_WIDTH`, 8: opcode width returned to `controlUnit`
- `clk`  in  1: single clock, all state on rising edge
- `rstN`  in  1: asynchronous, active-low reset
- `aluOp`  in  3: ALU operation code
- `incReg`  in  4: increment enables {PC, RC, RP, RQ} (bit3..bit0)
- `wrEnReg`  in  10: write enables {AR, R, PC, IR, RL, RC, RP, RQ, R1, AC} (bit9..bit0)
- `busSel`  in  4: bus source select
- `ZWrEn`  in  1: load Z flag from ALU result
- `iMemData`  in  REG_WIDTH: instruction memory read word (asynchronous read of `iAddr`)
- `dMemData`  in  REG_WIDTH: data memory read word (asynchronous read of `dAddr`)
- `iAddr`  out  REG_WIDTH: = PC
- `dAddr`  out  REG_WIDTH: = AR
- `dMemOut`  out  REG_WIDTH: = R (write data; write strobe is `controlUnit`'s `DataMemWrEn`)
- `ins`  out  INS_WIDTH: = IR[INS_WIDTH-1:0]
- `Zout`  out  1: Z flag register

## Operation
- Bus (combinational) by `busSel`: 0 zero, 1 PC, 2 dMemData, 3 R, 4 IR, 5 RL, 6 RC, 7 RP, 8 RQ, 9 R1, 10 AC, 11 iMemData; 12–15 zero.
- ALU (combinational), result `aluOut` modulo 2^REG_WIDTH: 0 PASS=bus, 1 ADD=AC+bus, 2 SUB=AC−bus, 3 MUL=low REG_WIDTH bits of AC×bus, 4 INC=AC+1, 5 CLR=0, 6/7 PASS.
- AC loads `aluOut` when `wrEnReg[0]`; every other register loads bus when its enable is set.
- Increment: register +1 when its `incReg` bit set; wraps all-ones → 0.
- Write and increment of same register in same cycle: write wins, increment dropped.
- Register selected as bus source and written in same cycle: reads old value (e.g. PC←PC is a hold).
- Z loads (`aluOut` == 0) when `ZWrEn`, else holds; independent of `wrEnReg[0]`.
- Any number of enables may be active simultaneously; each register independent.

## Timing
- All registers and Z reset asynchronously to 0 on `rstN`=0; outputs `iAddr`, `dAddr`, `dMemOut`, `ins`=0, `Zout`=0 during and after reset until first write.
- Reset mid-operation discards all state immediately; no pending writes survive.
- Write/increment latency 1 cycle: value visible on outputs after the enabling rising edge.
- `ins`, `Zout`, addresses are pure register outputs (no combinational path from control inputs).
- Bus→ALU→register is the single-cycle critical path; memories must be asynchronous-read.

## Structure
- Package `core_pkg`: bus-select codes, ALU op codes, `wrEnReg`/`incReg` bit indices; shared with `controlUnit`.
- Sub-module `alu` (aluOp, AC, bus → aluOut); registers, bus mux and Z in `processor_datapath`.

## Test plan
- Reset then idle: all outputs 0; PC inc 3 cycles → `iAddr`=3; PC write 0xFFF then inc → `iAddr`=0.
- Fetch: `iMemData`=0x00B, busSel=11, IR write → `ins`=0x0B next cycle; same cycle PC inc and PC write with bus=PC → write wins, PC unchanged.
- LDIAC/ADD: bus=iMemData 0x005, PASS into AC; then RP←AC, AC←ADD with bus=RP → AC=0x00A; SUB same → AC=0, with ZWrEn → `Zout`=1.
- MUL wrap: AC=0x040, RQ=0x041, MUL → AC=0x040 (0x1040 truncated); ZWrEn → `Zout`=0.
- Store path: AR←0x123, R←AC=0x7AB → `dAddr`=0x123, `dMemOut`=0x7AB; AC←dMemData 0x055 via busSel=2.
- Reset asserted mid-sequence with AC=0x7AB, Z=1 → all registers and `Zout` 0 immediately, without a clock edge.
